btn_cmd: RTL

BTN_CMD -- requirements
Module: btn_cmd

---
 rtl/btn_cmd.sv | 139 +++++++++++++
 1 files changed

// File: rtl/btn_cmd.sv
// btn_cmd: three synchronised, debounced pushbuttons feeding a run/direction
// command FSM with an optional run timeout.
module btn_cmd #(
    parameter int unsigned DB_CYCLES = 4,
    parameter logic [15:0] RUN_MAX   = 16'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_stop,
    output logic act,
    output logic h_l,
    output logic cmd_err,
    output logic tmo
);

    localparam logic [7:0] DC_LAST = 8'(DB_CYCLES - 1);
    localparam int UP   = 0;
    localparam int DN   = 1;
    localparam int STOP = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_UP = 2'd1,
        RUN_DN = 2'd2
    } state_t;

    logic [2:0]  btn_s;
    logic [2:0]  s1_r;
    logic [2:0]  s2_r;
    logic [2:0]  db_r;
    logic [2:0]  rise_r;
    logic [7:0]  dc_r [3];

    state_t      state_r;
    state_t      state_s;
    logic [15:0] timer_r;
    logic [15:0] timer_s;
    logic        run_cmd_s;
    logic        cmd_err_s;
    logic        tmo_s;
    logic        act_s;
    logic        hl_s;

    assign btn_s = {btn_stop, btn_dn, btn_up};

    // Synchronise, debounce and edge-detect each button; rise fires with the 0->1 db update.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r   <= 3'b000;
            s2_r   <= 3'b000;
            db_r   <= 3'b000;
            rise_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                dc_r[i] <= 8'd0;
            end
        end else begin
            s1_r <= btn_s;
            s2_r <= s1_r;
            for (int i = 0; i < 3; i++) begin
                rise_r[i] <= 1'b0;
                if (s2_r[i] == db_r[i]) begin
                    dc_r[i] <= 8'd0;
                end else if (dc_r[i] < DC_LAST) begin
                    dc_r[i] <= dc_r[i] + 8'd1;
                end else begin
                    db_r[i]   <= s2_r[i];
                    dc_r[i]   <= 8'd0;
                    rise_r[i] <= s2_r[i];
                end
            end
        end
    end

    // Command arbitration, timeout detection and run-timer update.
    always_comb begin
        state_s   = state_r;
        timer_s   = 16'd0;
        run_cmd_s = 1'b0;
        cmd_err_s = 1'b0;
        tmo_s     = 1'b0;
        if (rise_r[STOP]) begin
            state_s = IDLE;
        end else if (rise_r[UP] && rise_r[DN]) begin
            cmd_err_s = 1'b1;
        end else if (rise_r[UP]) begin
            state_s   = RUN_UP;
            run_cmd_s = 1'b1;
        end else if (rise_r[DN]) begin
            state_s   = RUN_DN;
            run_cmd_s = 1'b1;
        end else if ((state_r != IDLE) && (RUN_MAX != 16'd0) &&
                     (timer_r >= (RUN_MAX - 16'd1))) begin
            // >= rather than == so a rejected conflict on the last count cannot skip the timeout
            state_s = IDLE;
            tmo_s   = 1'b1;
        end else begin
            state_s = state_r;
        end

        if ((state_s == IDLE) || run_cmd_s || (state_r == IDLE)) begin
            timer_s = 16'd0;
        end else begin
            timer_s = timer_r + 16'd1;
        end
    end

    // Output decode from the next state; h_l keeps the last run direction while idle.
    always_comb begin
        act_s = (state_s != IDLE);
        hl_s  = h_l;
        case (state_s)
            RUN_UP:  hl_s = 1'b1;
            RUN_DN:  hl_s = 1'b0;
            default: hl_s = h_l;
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            timer_r <= 16'd0;
            act     <= 1'b0;
            h_l     <= 1'b1;
            cmd_err <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            act     <= act_s;
            h_l     <= hl_s;
            cmd_err <= cmd_err_s;
            tmo     <= tmo_s;
        end
    end

endmodule
